// File: rtl/wb_stage_if.sv
// Writeback stage port bundle: MEM-side instruction fields in, regfile write port
// and retire count out.
interface wb_stage_if;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [4:0]  rd_addr;
  logic        rd_wren;
  logic [1:0]  wb_sel;
  logic [31:0] alu_data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [31:0] ld_data;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;

  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_wren;
  logic        ld_err;
  logic [31:0] instret;

  modport master (
    output stall, flush, valid, rd_addr, rd_wren, wb_sel,
           alu_data, imm, pc, ld_data, funct3, addr_lo,
    input  wb_valid, wb_addr, wb_data, wb_wren, ld_err, instret
  );

  modport slave (
    input  stall, flush, valid, rd_addr, rd_wren, wb_sel,
           alu_data, imm, pc, ld_data, funct3, addr_lo,
    output wb_valid, wb_addr, wb_data, wb_wren, ld_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: load formatting, source mux and a single register stage
// driving the regfile write port, plus the retired-instruction counter.
module wb_stage (
  input  logic       i_clk,
  input  logic       i_rst_n,
  wb_stage_if.slave  s
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [31:0] wb_mux;
  logic        ld_bad;
  logic        err;
  logic        retire;

  always_comb begin
    ld_byte = s.ld_data[{s.addr_lo, 3'b000} +: 8];
    ld_half = s.addr_lo[1] ? s.ld_data[31:16] : s.ld_data[15:0];
    ld_fmt  = s.ld_data;
    ld_bad  = 1'b0;
    case (s.funct3)
      3'b000: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_fmt = {24'h0, ld_byte};
      3'b001: begin
        ld_fmt = {{16{ld_half[15]}}, ld_half};
        ld_bad = s.addr_lo[0];
      end
      3'b101: begin
        ld_fmt = {16'h0, ld_half};
        ld_bad = s.addr_lo[0];
      end
      3'b010: ld_bad = |s.addr_lo;
      default: ld_bad = 1'b1;
    endcase

    err = (s.wb_sel == 2'b01) & ld_bad;

    case (s.wb_sel)
      2'b00:   wb_mux = s.alu_data;
      2'b01:   wb_mux = ld_fmt;
      2'b10:   wb_mux = s.pc + 32'd4;
      default: wb_mux = s.imm;
    endcase

    retire = s.valid & ~err;
  end

  // Flush only clears the control bits; address/data are don't-care in a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s.wb_valid <= 1'b0;
      s.wb_wren  <= 1'b0;
      s.ld_err   <= 1'b0;
      s.wb_addr  <= 5'd0;
      s.wb_data  <= 32'd0;
      s.instret  <= 32'd0;
    end else if (s.flush) begin
      s.wb_valid <= 1'b0;
      s.wb_wren  <= 1'b0;
      s.ld_err   <= 1'b0;
    end else if (!s.stall) begin
      s.wb_valid <= s.valid;
      s.wb_addr  <= s.rd_addr;
      s.wb_data  <= wb_mux;
      s.ld_err   <= s.valid & err;
      s.wb_wren  <= retire & s.rd_wren & (s.rd_addr != 5'd0);
      if (retire) s.instret <= s.instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized + directed bench for wb_stage: a behavioural model pushes expected
// outputs into a queue and a monitor compares them after every rising edge.
module tb_wb_stage;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  wb_stage_if u_if ();

  wb_stage dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .s(u_if.slave));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic        wren;
    logic        err;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        dknown;
    logic [31:0] instret;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  exp_t        m;
  logic [31:0] rf  [32];
  logic [31:0] mrf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Regfile downstream samples the write port on the falling edge.
  always @(negedge i_clk)
    if (u_if.wb_wren) rf[u_if.wb_addr] <= u_if.wb_data;

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] off);
    int unsigned b, h;
    b = (w >> (32'(off) * 8)) & 32'hFF;
    h = (w >> (32'(off / 2) * 16)) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit load_bad(input logic [2:0] f, input logic [1:0] off);
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
    if ((f == 3'd1 || f == 3'd5) && (off % 2 == 1)) return 1'b1;
    if (f == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f3_defined(input logic [2:0] f);
    return !(f == 3'd3 || f == 3'd6 || f == 3'd7);
  endfunction

  task automatic model_reset();
    m.valid = 0; m.wren = 0; m.err = 0; m.addr = 0; m.data = 0;
    m.dknown = 1; m.instret = 0;
  endtask

  // Drive inputs (called at a falling edge) and push the state expected after the next rise.
  task automatic apply(input bit st, input bit fl, input bit v, input logic [4:0] rd,
                       input bit we, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] ld,
                       input logic [2:0] f3, input logic [1:0] off);
    bit bad;
    u_if.stall = st; u_if.flush = fl; u_if.valid = v; u_if.rd_addr = rd;
    u_if.rd_wren = we; u_if.wb_sel = sel; u_if.alu_data = alu; u_if.imm = imm;
    u_if.pc = pc; u_if.ld_data = ld; u_if.funct3 = f3; u_if.addr_lo = off;
    if (fl) begin
      m.valid = 0; m.wren = 0; m.err = 0; m.dknown = 0;
    end else if (!st) begin
      bad = (sel == 2'd1) && load_bad(f3, off);
      m.valid  = v;
      m.addr   = rd;
      m.dknown = 1;
      case (sel)
        2'd0: m.data = alu;
        2'd1: begin m.data = load_val(ld, f3, off); m.dknown = f3_defined(f3); end
        2'd2: m.data = pc + 32'd4;
        default: m.data = imm;
      endcase
      m.err  = v && bad;
      m.wren = v && we && rd != 0 && !bad;
      if (v && !bad) m.instret = m.instret + 1;
    end
    if (m.wren) mrf[m.addr] = m.data;
    q.push_back(m);
  endtask

  task automatic step(input bit st, input bit fl, input bit v, input logic [4:0] rd,
                      input bit we, input logic [1:0] sel, input logic [31:0] alu,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] ld,
                      input logic [2:0] f3, input logic [1:0] off);
    apply(st, fl, v, rd, we, sel, alu, imm, pc, ld, f3, off);
    @(negedge i_clk);
  endtask

  task automatic rand_step(input bit st, input bit fl);
    step(st, fl, $urandom_range(0, 9) < 8, 5'($urandom), $urandom_range(0, 9) < 8,
         2'($urandom), $urandom, $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom));
  endtask

  // Monitor: compares every registered output shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid", 32'(u_if.wb_valid), 32'(e.valid));
        chk("rd_wren", 32'(u_if.wb_wren), 32'(e.wren));
        chk("ld_err", 32'(u_if.ld_err), 32'(e.err));
        chk("instret", u_if.instret, e.instret);
        if (e.dknown) begin
          chk("rd_addr", 32'(u_if.wb_addr), 32'(e.addr));
          chk("rd_data", u_if.wb_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'hDEAD_0000 | 32'(i);
      mrf[i] = rf[i];
    end
    u_if.stall = 0; u_if.flush = 0; u_if.valid = 0; u_if.rd_addr = 0; u_if.rd_wren = 0;
    u_if.wb_sel = 0; u_if.alu_data = 0; u_if.imm = 0; u_if.pc = 0; u_if.ld_data = 0;
    u_if.funct3 = 0; u_if.addr_lo = 0;
    model_reset();

    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(u_if.wb_valid), 0);
    chk("rst_wren", 32'(u_if.wb_wren), 0);
    chk("rst_err", 32'(u_if.ld_err), 0);
    chk("rst_addr", 32'(u_if.wb_addr), 0);
    chk("rst_data", u_if.wb_data, 0);
    chk("rst_instret", u_if.instret, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // LB sign-extended byte 2, LHU upper half, misaligned LW
    step(0, 0, 1, 5, 1, 2'd1, 0, 0, 0, 32'h80FF_7F01, 3'd0, 2'd2);
    step(0, 0, 1, 6, 1, 2'd1, 0, 0, 0, 32'h8001_1234, 3'd5, 2'd2);
    step(0, 0, 1, 8, 1, 2'd1, 0, 0, 0, 32'h1234_5678, 3'd2, 2'd1);
    step(0, 0, 1, 9, 1, 2'd1, 0, 0, 0, 32'h0000_F080, 3'd1, 2'd0);
    step(0, 0, 1, 10, 1, 2'd1, 0, 0, 0, 32'h0000_F080, 3'd1, 2'd1);
    step(0, 0, 1, 11, 1, 2'd1, 0, 0, 0, 32'h0000_F080, 3'd6, 2'd0);
    // PC+4 wrap, rd=0 write suppression, immediate source
    step(0, 0, 1, 1, 1, 2'd2, 0, 0, 32'hFFFF_FFFC, 0, 3'd0, 2'd0);
    step(0, 0, 1, 0, 1, 2'd0, 32'hCAFE_F00D, 0, 0, 0, 3'd0, 2'd0);
    step(0, 0, 1, 12, 1, 2'd3, 0, 32'h0BAD_BEEF, 0, 0, 3'd0, 2'd0);
    // stall+flush gives bubble; then a capture frozen by three stalls
    step(1, 1, 1, 13, 1, 2'd0, 32'h1111_1111, 0, 0, 0, 3'd0, 2'd0);
    step(0, 0, 1, 14, 1, 2'd0, 32'h2222_2222, 0, 0, 0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) rand_step(1, 0);
    step(0, 0, 1, 15, 1, 2'd1, 0, 0, 0, 32'h1234_5678, 3'd2, 2'd3);
    for (int i = 0; i < 2; i++) rand_step(1, 0);
    step(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0);

    // Counter wrap from all-ones
    force u_if.instret = 32'hFFFF_FFFF;
    #1 release u_if.instret;
    m.instret = 32'hFFFF_FFFF;
    step(0, 0, 1, 16, 1, 2'd0, 32'h3333_3333, 0, 0, 0, 3'd0, 2'd0);
    step(0, 0, 1, 17, 1, 2'd0, 32'h4444_4444, 0, 0, 0, 3'd0, 2'd0);

    // Reset between edges while a write is pending: no regfile write may happen
    saved = mrf[7];
    apply(0, 0, 1, 7, 1, 2'd0, 32'h7777_7777, 0, 0, 0, 3'd0, 2'd0);
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(u_if.wb_valid), 0);
    chk("mid_rst_wren", 32'(u_if.wb_wren), 0);
    chk("mid_rst_err", 32'(u_if.ld_err), 0);
    chk("mid_rst_addr", 32'(u_if.wb_addr), 0);
    chk("mid_rst_data", u_if.wb_data, 0);
    chk("mid_rst_instret", u_if.instret, 0);
    @(negedge i_clk);
    #1;
    chk("mid_rst_rf7", rf[7], saved);
    mrf[7] = saved;
    model_reset();
    i_rst_n = 1'b1;
    step(0, 0, 1, 7, 1, 2'd3, 0, 32'h0000_0007, 0, 0, 3'd0, 2'd0);

    for (int i = 0; i < 400; i++)
      rand_step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
    step(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0);
    #2;

    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf[i], mrf[i]);
    if (q.size() != 0) chk("queue_drained", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
